// File: rtl/demux_pkg.sv
// Shared types and constants for the demux pulse counter.
package demux_pkg;

  // Snapshot handshake states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2
  } dpc_state_t;

  // Default counter and snapshot width.
  localparam int DPC_WIDTH = 8;

endpackage

// File: rtl/demux_pulse_counter_if.sv
// Snapshot handshake and frozen-result bundle of the demux pulse counter.
interface demux_pulse_counter_if #(
  parameter int WIDTH = 8
);

  logic             snap_req;
  logic             snap_ack;
  logic             snap_valid;
  logic [WIDTH-1:0] snap_y;
  logic [WIDTH-1:0] snap_z;
  logic             snap_ovf_y;
  logic             snap_ovf_z;

  // Requester side: raises req/ack, reads the frozen interval.
  modport master (
    output snap_req,
    output snap_ack,
    input  snap_valid,
    input  snap_y,
    input  snap_z,
    input  snap_ovf_y,
    input  snap_ovf_z
  );

  // Counter side: answers the handshake and presents the snapshot.
  modport slave (
    input  snap_req,
    input  snap_ack,
    output snap_valid,
    output snap_y,
    output snap_z,
    output snap_ovf_y,
    output snap_ovf_z
  );

endinterface

// File: rtl/demux_pulse_counter_edge_counter.sv
// Rising-edge detector feeding a saturating counter with a sticky overflow flag.
module edge_counter
  import demux_pkg::*;
#(
  parameter int WIDTH = DPC_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAX = '1;

  logic prev;
  logic edge_seen;

  assign edge_seen = in & ~prev;

  // prev resets high so a level already high at reset release is not an edge;
  // a clear coincident with an edge starts the new interval at one.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev  <= 1'b1;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      prev <= in;
      if (clear) begin
        count <= edge_seen ? ONE : '0;
        ovf   <= 1'b0;
      end else if (edge_seen) begin
        if (count == MAX) begin
          ovf <= 1'b1;
        end else begin
          count <= count + ONE;
        end
      end
    end
  end

endmodule

// File: rtl/demux_pulse_counter.sv
// Per-channel edge tally of the demux outputs with a four-phase snapshot handshake.
module demux_pulse_counter
  import demux_pkg::*;
#(
  parameter int WIDTH = DPC_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  y,
  input  logic                  z,
  demux_pulse_counter_if.slave  snap,
  output logic [WIDTH-1:0]      live_y,
  output logic [WIDTH-1:0]      live_z
);

  dpc_state_t state;
  dpc_state_t next_state;
  logic       capture;
  logic       ovf_y;
  logic       ovf_z;

  edge_counter #(.WIDTH(WIDTH)) u_count_y (
    .clock   (clock),
    .reset_n (reset_n),
    .in      (y),
    .clear   (capture),
    .count   (live_y),
    .ovf     (ovf_y)
  );

  edge_counter #(.WIDTH(WIDTH)) u_count_z (
    .clock   (clock),
    .reset_n (reset_n),
    .in      (z),
    .clear   (capture),
    .count   (live_z),
    .ovf     (ovf_z)
  );

  // Handshake state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Handshake next state; capture fires only on a request seen in IDLE.
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (snap.snap_req) begin
          capture    = 1'b1;
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (snap.snap_ack) begin
          next_state = RELEASE;
        end
      end
      RELEASE: begin
        if (!snap.snap_req && !snap.snap_ack) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Snapshot registers load the pre-capture counts and hold them until the next capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      snap.snap_y     <= '0;
      snap.snap_z     <= '0;
      snap.snap_ovf_y <= 1'b0;
      snap.snap_ovf_z <= 1'b0;
    end else if (capture) begin
      snap.snap_y     <= live_y;
      snap.snap_z     <= live_z;
      snap.snap_ovf_y <= ovf_y;
      snap.snap_ovf_z <= ovf_z;
    end
  end

  assign snap.snap_valid = (state == HOLD);

endmodule

// File: tb/tb_demux_pulse_counter.sv
// Directed bench for demux_pulse_counter: vector table plus multi-cycle corner sequences.
module tb_demux_pulse_counter;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       y8, z8, y4, z4;
  logic [7:0] live_y8, live_z8;
  logic [3:0] live_y4, live_z4;

  int checks   = 0;
  int failures = 0;

  demux_pulse_counter_if #(.WIDTH(8)) sif8 ();
  demux_pulse_counter_if #(.WIDTH(4)) sif4 ();

  demux_pulse_counter #(.WIDTH(8)) dut8 (
    .clock   (clock),
    .reset_n (reset_n),
    .y       (y8),
    .z       (z8),
    .snap    (sif8.slave),
    .live_y  (live_y8),
    .live_z  (live_z8)
  );

  demux_pulse_counter #(.WIDTH(4)) dut4 (
    .clock   (clock),
    .reset_n (reset_n),
    .y       (y4),
    .z       (z4),
    .snap    (sif4.slave),
    .live_y  (live_y4),
    .live_z  (live_z4)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       y;
    logic       z;
    logic       req;
    logic       ack;
    logic [7:0] live_y;
    logic [7:0] live_z;
    logic       valid;
    logic [7:0] snap_y;
    logic [7:0] snap_z;
  } vec_t;

  vec_t vecs [18];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic pulse8(input int n, input logic on_y, input logic on_z);
    for (int i = 0; i < n; i++) begin
      y8 = on_y; z8 = on_z; tick();
      y8 = 1'b0; z8 = 1'b0; tick();
    end
  endtask

  task automatic snapshot8();
    sif8.snap_req = 1'b1; tick();
    sif8.snap_ack = 1'b1; tick();
    sif8.snap_req = 1'b0; sif8.snap_ack = 1'b0; tick();
  endtask

  task automatic snapshot4();
    sif4.snap_req = 1'b1; tick();
    sif4.snap_ack = 1'b1; tick();
    sif4.snap_req = 1'b0; sif4.snap_ack = 1'b0; tick();
  endtask

  task automatic applyStimulus();
    //          y     z     req   ack   ly    lz    vld   sy    sz
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 8'd1, 1'b0, 8'd0, 8'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd1, 1'b0, 8'd0, 8'd0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 8'd1, 1'b0, 8'd0, 8'd0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 8'd2, 1'b0, 8'd0, 8'd0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd3, 8'd2, 1'b0, 8'd0, 8'd0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd3, 8'd3, 1'b0, 8'd0, 8'd0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd4, 8'd3, 1'b0, 8'd0, 8'd0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd4, 8'd3, 1'b0, 8'd0, 8'd0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd5, 8'd3, 1'b0, 8'd0, 8'd0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 8'd5, 8'd3};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 8'd5, 8'd3};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 8'd0, 1'b0, 8'd5, 8'd3};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 1'b0, 8'd5, 8'd3};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 8'd5, 8'd3};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 8'd0, 8'd0};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0};
  endtask

  initial begin
    reset_n = 1'b0;
    y8 = 1'b0; z8 = 1'b0; y4 = 1'b0; z4 = 1'b0;
    sif8.snap_req = 1'b0; sif8.snap_ack = 1'b0;
    sif4.snap_req = 1'b0; sif4.snap_ack = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    checkOutput("reset_valid", sif8.snap_valid, 0);
    checkOutput("reset_live_y", live_y8, 0);
    checkOutput("reset_live_z", live_z8, 0);
    checkOutput("reset_snap_y", sif8.snap_y, 0);
    checkOutput("reset_ovf_y", sif8.snap_ovf_y, 0);

    // Basic counting and a full handshake from the vector table.
    applyStimulus();
    for (int i = 0; i < 18; i++) begin
      y8 = vecs[i].y; z8 = vecs[i].z;
      sif8.snap_req = vecs[i].req; sif8.snap_ack = vecs[i].ack;
      tick();
      checkOutput($sformatf("vec%0d_live_y", i), live_y8, vecs[i].live_y);
      checkOutput($sformatf("vec%0d_live_z", i), live_z8, vecs[i].live_z);
      checkOutput($sformatf("vec%0d_valid", i), sif8.snap_valid, vecs[i].valid);
      checkOutput($sformatf("vec%0d_snap_y", i), sif8.snap_y, vecs[i].snap_y);
      checkOutput($sformatf("vec%0d_snap_z", i), sif8.snap_z, vecs[i].snap_z);
      checkOutput($sformatf("vec%0d_ovf_y", i), sif8.snap_ovf_y, 0);
      checkOutput($sformatf("vec%0d_ovf_z", i), sif8.snap_ovf_z, 0);
    end

    // Saturation on the 4-bit instance.
    for (int i = 0; i < 17; i++) begin
      y4 = 1'b1; tick();
      y4 = 1'b0; tick();
    end
    checkOutput("w4_live_sat", live_y4, 15);
    snapshot4();
    checkOutput("w4_snap_y", sif4.snap_y, 15);
    checkOutput("w4_snap_ovf_y", sif4.snap_ovf_y, 1);
    checkOutput("w4_snap_ovf_z", sif4.snap_ovf_z, 0);
    checkOutput("w4_live_after", live_y4, 0);
    y4 = 1'b1; tick();
    y4 = 1'b0; tick();
    snapshot4();
    checkOutput("w4_next_snap_y", sif4.snap_y, 1);
    checkOutput("w4_next_ovf_y", sif4.snap_ovf_y, 0);

    // Edge in the capture cycle belongs to the new interval.
    pulse8(2, 1'b1, 1'b0);
    y8 = 1'b1; sif8.snap_req = 1'b1; tick();
    checkOutput("cap_snap_y", sif8.snap_y, 2);
    checkOutput("cap_live_y", live_y8, 1);
    checkOutput("cap_valid", sif8.snap_valid, 1);
    y8 = 1'b0; sif8.snap_ack = 1'b1; tick();
    sif8.snap_req = 1'b0; sif8.snap_ack = 1'b0; tick();
    snapshot8();
    checkOutput("cap_second_snap_y", sif8.snap_y, 1);

    // Simultaneous edges on both channels.
    pulse8(4, 1'b1, 1'b1);
    checkOutput("both_live_y", live_y8, 4);
    checkOutput("both_live_z", live_z8, 4);

    // Edges while holding: snapshot frozen, live keeps counting.
    sif8.snap_req = 1'b1; tick();
    checkOutput("hold_snap_z", sif8.snap_z, 4);
    pulse8(6, 1'b0, 1'b1);
    checkOutput("hold_valid", sif8.snap_valid, 1);
    checkOutput("hold_snap_z_frozen", sif8.snap_z, 4);
    checkOutput("hold_snap_y_frozen", sif8.snap_y, 4);
    checkOutput("hold_live_z", live_z8, 6);
    sif8.snap_ack = 1'b1; tick();
    sif8.snap_req = 1'b0; sif8.snap_ack = 1'b0; tick();
    snapshot8();
    checkOutput("hold_second_snap_z", sif8.snap_z, 6);

    // Asynchronous reset in HOLD with a y level held through release.
    sif8.snap_req = 1'b1; tick();
    pulse8(7, 1'b1, 1'b0);
    checkOutput("rst_pre_live_y", live_y8, 7);
    checkOutput("rst_pre_valid", sif8.snap_valid, 1);
    y8 = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst_valid", sif8.snap_valid, 0);
    checkOutput("rst_live_y", live_y8, 0);
    checkOutput("rst_live_z", live_z8, 0);
    checkOutput("rst_snap_z", sif8.snap_z, 0);
    checkOutput("rst_w4_snap_y", sif4.snap_y, 0);
    sif8.snap_req = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    checkOutput("rst_held_high_live_y", live_y8, 0);
    checkOutput("rst_after_valid", sif8.snap_valid, 0);
    y8 = 1'b0; tick();
    y8 = 1'b1; tick();
    checkOutput("rst_new_edge_live_y", live_y8, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
